// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle main control FSM: state encodings,
// opcode map, ALUop codes and an opcode-legality helper.
// The TRAP encoding is reserved here. The FSM only reaches it when the design
// is built with ILLEGAL_OPCODE_TRAP_EN defined.
package mc_ctrl_pkg;

    // State encodings. Codes 14 and 15 are unused and fall back to RST.
    localparam logic [3:0] RST      = 4'd0;
    localparam logic [3:0] FETCH    = 4'd1;
    localparam logic [3:0] DECODE   = 4'd2;
    localparam logic [3:0] MEM_ADDR = 4'd3;
    localparam logic [3:0] MEM_RD   = 4'd4;
    localparam logic [3:0] MEM_WB   = 4'd5;
    localparam logic [3:0] MEM_WR   = 4'd6;
    localparam logic [3:0] R_EXEC   = 4'd7;
    localparam logic [3:0] R_WB     = 4'd8;
    localparam logic [3:0] I_EXEC   = 4'd9;
    localparam logic [3:0] I_WB     = 4'd10;
    localparam logic [3:0] BRANCH   = 4'd11;
    localparam logic [3:0] JUMP     = 4'd12;
    localparam logic [3:0] TRAP     = 4'd13;

    // Opcodes taken from instr[31:26].
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;

    // ALUop codes consumed by ALU_Control_Unit.
    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_SLT   = 3'b010;
    localparam logic [2:0] ALUOP_ADD   = 3'b011;

    // True for every opcode the datapath knows how to execute.
    function automatic logic is_known_op(input logic [5:0] op);
        logic known;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_SLTI, OP_J: known = 1'b1;
            default:                known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational decoder from the current state, opcode and mem_ready to
// every datapath control output.
// With ILLEGAL_OPCODE_TRAP_EN, TRAP raises illegal_op. Without it, an unknown
// opcode in DECODE retires as a NOP.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] state_i,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       instr_done,
    output logic       illegal_op
);

    // Decode control outputs; anything not driven for a state stays 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        pc_source     = 2'b00;
        alu_op        = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_i)
            RST: begin
                illegal_op = 1'b0;
            end
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_ADD;
                // IR and PC only commit once the instruction word has arrived.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_op    = ALUOP_ADD;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                instr_done = 1'b0;
`else
                instr_done = ~is_known_op(opcode);
`endif
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = ALUOP_ADD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_RTYPE;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // IR is frozen outside FETCH, so the opcode is still valid here.
                if (opcode == OP_SLTI) begin
                    alu_op = ALUOP_SLT;
                end else begin
                    alu_op = ALUOP_ADD;
                end
            end
            I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
            end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            TRAP: begin
                illegal_op = 1'b1;
            end
`endif
            default: begin
                illegal_op = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle datapath. It holds the state register
// and the next-state logic, and it delegates output decoding to
// mc_ctrl_outdec.
// Defining ILLEGAL_OPCODE_TRAP_EN makes unknown opcodes trap in TRAP until
// reset. Without the macro, unknown opcodes retire as NOPs.
module multicycle_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] Opcode,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           MemtoReg,
    output logic [1:0]     PCSource,
    output logic [2:0]     ALUop,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic           RegWrite,
    output logic           RegDst,
    output logic           instr_done,
    output logic           illegal_op
);

    logic [STW-1:0] state_d;
    logic [STW-1:0] state_q;

    // Next-state sequencing; unused encodings recover through RST.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RST: state_d = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:     state_d = MEM_ADDR;
                    OP_R:             state_d = R_EXEC;
                    OP_BEQ:           state_d = BRANCH;
                    OP_ADDI, OP_SLTI: state_d = I_EXEC;
                    OP_J:             state_d = JUMP;
`ifdef ILLEGAL_OPCODE_TRAP_EN
                    default:          state_d = TRAP;
`else
                    default:          state_d = FETCH;
`endif
                endcase
            end
            MEM_ADDR: begin
                if (Opcode == OP_SW) begin
                    state_d = MEM_WR;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ready) begin
                    state_d = MEM_WB;
                end else begin
                    state_d = MEM_RD;
                end
            end
            MEM_WB: state_d = FETCH;
            MEM_WR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                end else begin
                    state_d = MEM_WR;
                end
            end
            R_EXEC: state_d = R_WB;
            R_WB:   state_d = FETCH;
            I_EXEC: state_d = I_WB;
            I_WB:   state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
`ifdef ILLEGAL_OPCODE_TRAP_EN
            TRAP:   state_d = TRAP;
`endif
            default: state_d = RST;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    mc_ctrl_outdec u_outdec (
        .state_i       (state_q),
        .opcode        (Opcode[5:0]),
        .mem_ready     (mem_ready),
        .pc_write      (PCWrite),
        .pc_write_cond (PCWriteCond),
        .i_or_d        (IorD),
        .mem_read      (MemRead),
        .mem_write     (MemWrite),
        .ir_write      (IRWrite),
        .mem_to_reg    (MemtoReg),
        .pc_source     (PCSource),
        .alu_op        (ALUop),
        .alu_src_a     (ALUSrcA),
        .alu_src_b     (ALUSrcB),
        .reg_write     (RegWrite),
        .reg_dst       (RegDst),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control. Each instruction is
// modelled as a list of datapath steps, and every step has its own control
// word. A step that waits on memory repeats while mem_ready is low.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic [1:0] PCSource;
    logic [2:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite, RegDst, instr_done, illegal_op;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.OPW(6), .STW(4)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUop(ALUop),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op)
    );

    typedef struct {
        logic [19:0] base;   // control word that is always present
        logic [19:0] rdy;    // extra bits present only when mem_ready=1
        bit          waits;  // step repeats while mem_ready=0
        bit          fetch;
        string       name;
    } step_t;

    step_t steps[$];

    // Pack one control word from named fields.
    function automatic logic [19:0] w(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic [1:0] pcs,
        input logic [2:0] aop, input logic asa, input logic [1:0] asb,
        input logic rw, input logic rd, input logic done, input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, pcs, aop, asa, asb, rw, rd, done, ill};
    endfunction

    function automatic logic [19:0] obs();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done, illegal_op};
    endfunction

    function automatic bit known(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b001010) ||
               (op == 6'b000010);
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp);
        tests++;
        assert (obs() === exp) else begin
            fails++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs(), exp);
        end
    endtask

    task automatic push(input string n, input logic [19:0] b, input logic [19:0] r,
                        input bit wt, input bit f);
        step_t s;
        s.name = n; s.base = b; s.rdy = r; s.waits = wt; s.fetch = f;
        steps.push_back(s);
    endtask

    // Step list of one instruction, from fetch to retire.
    task automatic build(input logic [5:0] op);
        steps.delete();
        push("FETCH", w(0,0,0,1,0,0,0,2'b00,3'b011,0,2'b01,0,0,0,0),
                      w(1,0,0,0,0,1,0,2'b00,3'b000,0,2'b00,0,0,0,0), 1, 1);
        push("DECODE", w(0,0,0,0,0,0,0,2'b00,3'b011,0,2'b11,0,0,
`ifdef ILLEGAL_OPCODE_TRAP_EN
                         0,
`else
                         !known(op),
`endif
                         0), 20'd0, 0, 0);
        case (op)
            6'b000000: begin
                push("R_EXEC", w(0,0,0,0,0,0,0,2'b00,3'b000,1,2'b00,0,0,0,0), 20'd0, 0, 0);
                push("R_WB",   w(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,1,1,1,0), 20'd0, 0, 0);
            end
            6'b100011: begin
                push("LW_ADDR", w(0,0,0,0,0,0,0,2'b00,3'b011,1,2'b10,0,0,0,0), 20'd0, 0, 0);
                push("MEM_RD",  w(0,0,1,1,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0), 20'd0, 1, 0);
                push("MEM_WB",  w(0,0,0,0,0,0,1,2'b00,3'b000,0,2'b00,1,0,1,0), 20'd0, 0, 0);
            end
            6'b101011: begin
                push("SW_ADDR", w(0,0,0,0,0,0,0,2'b00,3'b011,1,2'b10,0,0,0,0), 20'd0, 0, 0);
                push("MEM_WR",  w(0,0,1,0,1,0,0,2'b00,3'b000,0,2'b00,0,0,0,0),
                                w(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,1,0), 1, 0);
            end
            6'b000100:
                push("BRANCH", w(0,1,0,0,0,0,0,2'b01,3'b001,1,2'b00,0,0,1,0), 20'd0, 0, 0);
            6'b001000, 6'b001010: begin
                push("I_EXEC", w(0,0,0,0,0,0,0,2'b00,(op == 6'b001010) ? 3'b010 : 3'b011,
                                 1,2'b10,0,0,0,0), 20'd0, 0, 0);
                push("I_WB",   w(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,1,0,1,0), 20'd0, 0, 0);
            end
            6'b000010:
                push("JUMP", w(1,0,0,0,0,0,0,2'b10,3'b000,0,2'b00,0,0,1,0), 20'd0, 0, 0);
            default: ;
        endcase
    endtask

    // Hold reset for ncyc edges, then release it. The release cycle is still RST.
    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("RESET", 20'd0);
        end
        rst = 1'b0;
        mem_ready = 1'b1;
        #1 chk("RESET_RELEASE", 20'd0);
        @(posedge clk); #1;
    endtask

    // Run one instruction. With rnd=0, FETCH is ready at once and a memory
    // step waits nwait cycles. If abort_at is a valid step index, reset is
    // asserted during that step while the step is still waiting.
    task automatic run_instr(input logic [5:0] op, input bit rnd, input int nwait,
                             input int abort_at);
        Opcode = op;
        build(op);
        for (int k = 0; k < steps.size(); k++) begin
            int  zeros = 0;
            bit  adv   = 1'b0;
            while (!adv) begin
                logic       r;
                logic [19:0] exp;
                if (k == abort_at) begin
                    mem_ready = 1'b0;
                    #1 chk({steps[k].name, "_PRE_ABORT"}, steps[k].base);
                    do_reset(1);
                    return;
                end
                if (!steps[k].waits)  r = 1'($urandom_range(0, 1));
                else if (rnd)         r = (zeros >= 6) ? 1'b1 : 1'($urandom_range(0, 2) != 0);
                else if (steps[k].fetch) r = 1'b1;
                else                  r = (zeros >= nwait);
                mem_ready = r;
                exp = (steps[k].waits && !r) ? steps[k].base : (steps[k].base | steps[k].rdy);
                #1 chk(steps[k].name, exp);
                @(posedge clk); #1;
                if (!steps[k].waits || r) adv = 1'b1;
                else zeros++;
            end
        end
`ifdef ILLEGAL_OPCODE_TRAP_EN
        if (!known(op)) begin
            for (int i = 0; i < 3; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                #1 chk("TRAP", w(0,0,0,0,0,0,0,2'b00,3'b000,0,2'b00,0,0,0,1));
                @(posedge clk); #1;
            end
            do_reset(1);
        end
`endif
    endtask

    logic [5:0] optab [8];

    initial begin
        optab[0] = 6'b000000; optab[1] = 6'b100011; optab[2] = 6'b101011;
        optab[3] = 6'b000100; optab[4] = 6'b001000; optab[5] = 6'b001010;
        optab[6] = 6'b000010; optab[7] = 6'b111111;
        rst = 1'b1; mem_ready = 1'b0; Opcode = 6'd0;

        do_reset(2);
        run_instr(6'b000000, 0, 0, -1);   // R-type
        run_instr(6'b100011, 0, 3, -1);   // LW with 3 memory wait cycles
        run_instr(6'b000100, 0, 0, -1);   // BEQ
        run_instr(6'b001010, 0, 0, -1);   // SLTI
        run_instr(6'b001000, 0, 0, -1);   // ADDI
        run_instr(6'b101011, 0, 2, -1);   // SW with waits
        run_instr(6'b000010, 0, 0, -1);   // J
        run_instr(6'b111111, 0, 0, -1);   // unknown opcode
        run_instr(6'b101011, 0, 5, 3);    // reset during MEM_WR
        run_instr(6'b100011, 0, 0, 3);    // reset during MEM_RD

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                if (known(op)) op = 6'b111111;
            end else begin
                op = optab[$urandom_range(0, 6)];
            end
            run_instr(op, 1, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
